// File: rtl/srows_pipe.sv
// Registered AES/Rijndael ShiftRows stage (NB = 4/6/8) with valid/ready and a 2-entry skid buffer.
// Optional inverse mode is enabled by defining SROWS_INV_EN.
//
// state | meaning
// EMPTY | no state held, out_valid low
// ONE   | MAIN holds the oldest state, SKID empty
// FULL  | MAIN and SKID both hold states, in_ready low
module srows_pipe #(
  parameter int NB    = 4,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [32*NB-1:0]   olddata,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               decrypt,
  output logic [32*NB-1:0]   newdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               srows_finished,
  output logic [CNT_W-1:0]   blk_count
);

  localparam int W  = 32 * NB;
  localparam int RW = 8 * NB;

  if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
    $error("srows_pipe: NB must be 4, 6 or 8");
  end

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     main_q, main_d;
  logic [W-1:0]     skid_q, skid_d;
  logic             in_ready_q, in_ready_d;
  logic             fin_q, fin_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     shifted;
  logic             accept, handshake;

  // Byte c of row r takes source byte (c +/- C(r)) mod NB; all indices are elaboration constants.
  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < NB; c++) begin : g_byte
      localparam int OFF = (NB == 8 && r >= 2) ? r + 1 : r;
      localparam int DST = W - 1 - r*RW - c*8;
      localparam int FWD = W - 1 - r*RW - ((c + OFF) % NB)*8;
`ifdef SROWS_INV_EN
      localparam int INV = W - 1 - r*RW - ((c - OFF + NB) % NB)*8;
      assign shifted[DST -: 8] = decrypt ? olddata[INV -: 8] : olddata[FWD -: 8];
`else
      assign shifted[DST -: 8] = olddata[FWD -: 8];
`endif
    end
  end

`ifndef SROWS_INV_EN
  logic unused_decrypt;
  assign unused_decrypt = decrypt;
`endif

  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid && in_ready_q;
  assign handshake = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    fin_d   = handshake;
    cnt_d   = handshake ? cnt_q + CNT_W'(1) : cnt_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          main_d  = shifted;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && handshake) begin
          main_d = shifted;
        end else if (accept) begin
          skid_d  = shifted;
          state_d = FULL;
        end else if (handshake) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (handshake) begin
          main_d  = skid_q;
          skid_d  = '0;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    in_ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
      fin_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
      fin_q      <= fin_d;
      cnt_q      <= cnt_d;
    end
  end

  assign in_ready       = in_ready_q;
  assign newdata        = main_q;
  assign srows_finished = fin_q;
  assign blk_count      = cnt_q;

endmodule

// File: tb/tb_srows_pipe.sv
// Bench for srows_pipe: an NB=4/CNT_W=16 and an NB=8/CNT_W=4 instance share one control stream
// and are checked against a byte-matrix ShiftRows reference and a 2-deep FIFO model.
module tb_srows_pipe;

`ifdef SROWS_INV_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, in_valid, out_ready, decrypt;
  logic [127:0] d4, nd4;
  logic [255:0] d8, nd8;
  logic         ir4, ir8, ov4, ov8, fin4, fin8;
  logic [15:0]  bc4;
  logic [3:0]   bc8;

  always #5 clk = ~clk;

  srows_pipe #(.NB(4), .CNT_W(16)) dut4 (
    .clk(clk), .rst(rst), .olddata(d4), .in_valid(in_valid), .in_ready(ir4),
    .decrypt(decrypt), .newdata(nd4), .out_valid(ov4), .out_ready(out_ready),
    .srows_finished(fin4), .blk_count(bc4));

  srows_pipe #(.NB(8), .CNT_W(4)) dut8 (
    .clk(clk), .rst(rst), .olddata(d8), .in_valid(in_valid), .in_ready(ir8),
    .decrypt(decrypt), .newdata(nd8), .out_valid(ov8), .out_ready(out_ready),
    .srows_finished(fin8), .blk_count(bc8));

  int n_chk = 0;
  int n_pass = 0;

  logic [127:0] q4[$];
  logic [255:0] q8[$];
  int           cnt_exp = 0;
  bit           fin_exp = 1'b0;

  // Reference: data in the low 32*nb bits, byte k (k = r*nb + c) counted from the MSB.
  function automatic logic [255:0] ref_rows(logic [255:0] d, int nb, bit inv);
    logic [7:0]   st[4][8];
    logic [255:0] res = '0;
    int           nbytes = 4 * nb;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < nb; c++)
        st[r][c] = d[(nbytes - 1 - (r*nb + c))*8 +: 8];
    for (int r = 0; r < 4; r++) begin
      int s = (nb == 8 && r >= 2) ? r + 1 : r;
      for (int c = 0; c < nb; c++)
        res[(nbytes - 1 - (r*nb + c))*8 +: 8] = inv ? st[r][(c - s + nb) % nb] : st[r][(c + s) % nb];
    end
    return res;
  endfunction

  task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_all();
    bit has = (q4.size() > 0);
    chk("out_valid4", 256'(ov4), 256'(has));
    chk("out_valid8", 256'(ov8), 256'(has));
    chk("in_ready4", 256'(ir4), 256'(q4.size() < 2));
    chk("in_ready8", 256'(ir8), 256'(q4.size() < 2));
    chk("finished4", 256'(fin4), 256'(fin_exp));
    chk("finished8", 256'(fin8), 256'(fin_exp));
    chk("blk_count4", 256'(bc4), 256'(cnt_exp % 65536));
    chk("blk_count8", 256'(bc8), 256'(cnt_exp % 16));
    if (has) begin
      chk("newdata4", 256'(nd4), 256'(q4[0]));
      chk("newdata8", nd8, q8[0]);
    end
  endtask

  task automatic step();
    logic [255:0] e;
    bit           hs, acc;
    @(posedge clk);
    if (rst) begin
      q4.delete(); q8.delete();
      cnt_exp = 0;
      fin_exp = 1'b0;
    end else begin
      hs  = (q4.size() > 0) && out_ready;
      acc = in_valid && (q4.size() < 2);
      fin_exp = hs;
      if (hs) begin
        void'(q4.pop_front());
        void'(q8.pop_front());
        cnt_exp++;
      end
      if (acc) begin
        e = ref_rows(256'(d4), 4, decrypt && INV_EN);
        q4.push_back(e[127:0]);
        q8.push_back(ref_rows(d8, 8, decrypt && INV_EN));
      end
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic rand_data();
    d4 = {$urandom(), $urandom(), $urandom(), $urandom()};
    d8 = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  initial begin
    logic [127:0] held;
    int           fins;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; decrypt = 1'b0; d4 = '0; d8 = '0;
    step(); step();
    rst = 1'b0;
    step();
    chk("reset_newdata4", 256'(nd4), 256'd0);
    chk("reset_newdata8", nd8, 256'd0);

    // Known-answer vectors, forward mode
    d4 = 128'h00010203_04050607_08090a0b_0c0d0e0f;
    d8 = 256'h00010203_04050607_08090a0b_0c0d0e0f_10111213_14151617_18191a1b_1c1d1e1f;
    in_valid = 1'b1; out_ready = 1'b1;
    step();
    chk("kat_fwd4", 256'(nd4), 256'(128'h00010203_05060704_0a0b0809_0f0c0d0e));
    chk("kat_fwd8", nd8, 256'h00010203_04050607_090a0b0c_0d0e0f08_13141516_17101112_1c1d1e1f_18191a1b);
    in_valid = 1'b0;
    step();
    chk("kat_fin", 256'(fin4), 256'd1);
    chk("kat_cnt", 256'(bc4), 256'd1);
    step();

    // Inverse vector (forward result when the inverse path is compiled out)
    d4 = 128'h00010203_05060704_0a0b0809_0f0c0d0e;
    decrypt = 1'b1; in_valid = 1'b1;
    step();
    chk("kat_inv4", 256'(nd4), INV_EN ? 256'(128'h00010203_04050607_08090a0b_0c0d0e0f)
                                       : 256'(128'h00010203_06070405_08090a0b_0e0f0c0d));
    in_valid = 1'b0; decrypt = 1'b0;
    step(); step();

    // Backpressure: three offers, only two fit
    out_ready = 1'b0; in_valid = 1'b1;
    rand_data(); step();
    held = nd4;
    rand_data(); step();
    chk("bp_in_ready_low", 256'(ir4), 256'd0);
    rand_data(); step(); step(); step();
    chk("bp_stable", 256'(nd4), 256'(held));
    out_ready = 1'b1;
    step(); step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();

    // Streaming 20 blocks from a fresh reset
    rst = 1'b1; step(); rst = 1'b0;
    fins = 0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rand_data(); decrypt = 1'($urandom_range(0, 1));
      step();
      if (fin4) fins++;
    end
    in_valid = 1'b0;
    step();
    if (fin4) fins++;
    chk("stream_fin_cycles", 256'(fins), 256'd20);
    chk("stream_cnt4", 256'(bc4), 256'd20);
    chk("stream_cnt8_wrap", 256'(bc8), 256'd4);
    step();

    // Reset with a full buffer
    out_ready = 1'b0; in_valid = 1'b1;
    rand_data(); step(); rand_data(); step();
    rst = 1'b1; step(); rst = 1'b0; in_valid = 1'b0;
    chk("rst_full_out_valid", 256'(ov4), 256'd0);
    chk("rst_full_in_ready", 256'(ir4), 256'd1);
    chk("rst_full_cnt", 256'(bc4), 256'd0);
    step();

    // 17 handshakes wrap the 4-bit counter to 1
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin rand_data(); step(); end
    in_valid = 1'b0;
    step();
    chk("wrap_cnt8", 256'(bc8), 256'd1);
    chk("wrap_cnt4", 256'(bc4), 256'd17);

    // Random traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 63) == 0);
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      decrypt   = 1'($urandom_range(0, 1));
      rand_data();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
